// File: rtl/video_pattern_source_pkg.sv
// Shared constants and types for the video pattern source.
// Register map, pattern encodings, RGB565 bar palette.
package video_pattern_source_pkg;

    typedef logic [15:0] rgb565_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] bar;
        logic [6:0] bcnt;
    } pos_t;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_PAT  = 2'd1;
    localparam logic [1:0] REG_FG   = 2'd2;
    localparam logic [1:0] REG_STAT = 2'd3;

    localparam logic [2:0] PAT_SOLID = 3'd0;
    localparam logic [2:0] PAT_BARS  = 3'd1;
    localparam logic [2:0] PAT_GRAD  = 3'd2;
    localparam logic [2:0] PAT_CHECK = 3'd3;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    localparam rgb565_t BAR_WHITE   = 16'hFFFF;
    localparam rgb565_t BAR_YELLOW  = 16'hFFE0;
    localparam rgb565_t BAR_CYAN    = 16'h07FF;
    localparam rgb565_t BAR_GREEN   = 16'h07E0;
    localparam rgb565_t BAR_MAGENTA = 16'hF81F;
    localparam rgb565_t BAR_RED     = 16'hF800;
    localparam rgb565_t BAR_BLUE    = 16'h001F;
    localparam rgb565_t BAR_BLACK   = 16'h0000;

    function automatic rgb565_t bar_color(input logic [2:0] idx);
        rgb565_t c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/video_pattern_source_if.sv
// Avalon-MM control slave plus Avalon-ST video source bundle.
// slave = pattern source side, master = host / sink side.
interface video_pattern_source_if;

    logic        chipselect;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic        valid_out;
    logic        ready_in;
    logic [15:0] data_out;
    logic        startofpacket_out;
    logic        endofpacket_out;

    modport slave (
        input  chipselect, address, write, writedata, read, ready_in,
        output readdata, valid_out, data_out,
        output startofpacket_out, endofpacket_out
    );

    modport master (
        output chipselect, address, write, writedata, read, ready_in,
        input  readdata, valid_out, data_out,
        input  startofpacket_out, endofpacket_out
    );

endinterface

// File: rtl/video_pattern_source_gen.sv
// Combinational pixel colour for one (x, y) position.
// Bar index comes from the caller's sub-counter.
module video_pattern_gen
    import video_pattern_source_pkg::*;
(
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [2:0] bar_idx,
    input  logic [2:0] pat,
    input  rgb565_t    fg,
    output rgb565_t    pix
);

    logic unused_xy;
    assign unused_xy = ^{x[9:8], y[9:5], y[3:0]};

    // Select the colour for the requested pattern.
    always_comb begin
        pix = fg;
        unique case (1'b1)
            (pat == PAT_BARS):  pix = bar_color(bar_idx);
            (pat == PAT_GRAD):  pix = {x[7:3], x[7:2], x[7:3]};
            (pat == PAT_CHECK): pix = (x[4] ^ y[4]) ? ~fg : fg;
            default:            pix = fg;
        endcase
    end

endmodule

// File: rtl/video_pattern_source.sv
// RGB565 test-frame generator with Avalon-ST output.
// Configured through a 4-word Avalon-MM register slave.
module video_pattern_source
    import video_pattern_source_pkg::*;
#(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input logic                   clk,
    input logic                   reset,
    video_pattern_source_if.slave bus
);

    localparam logic [9:0] XMAX = 10'(WIDTH - 1);
    localparam logic [9:0] YMAX = 10'(HEIGHT - 1);
    localparam logic [6:0] BMAX = 7'(WIDTH / 8 - 1);

    logic [0:0]  state;
    logic        enable;
    logic        single_frame;
    logic [2:0]  pattern_sel;
    rgb565_t     fg_color;
    logic [15:0] frame_count;
    logic [2:0]  sh_pat;
    rgb565_t     sh_fg;
    pos_t        pos;
    pos_t        pos_n;
    logic [2:0]  pat_n;
    rgb565_t     fg_n;
    rgb565_t     pix;
    logic        xfer;
    logic        eop_xfer;
    logic        start;
    logic        busy;
    logic        sop_n;
    logic        eop_n;
    logic        wr;
    logic        rd;
    logic        unused_wd;

    assign unused_wd = ^bus.writedata[31:16];

    // Next pixel position and frame shadows, advanced per accepted beat.
    always_comb begin
        xfer     = bus.valid_out && bus.ready_in;
        eop_xfer = xfer && bus.endofpacket_out;
        busy     = (state == ST_STREAM);
        start    = (!busy && enable) ||
                   (eop_xfer && !single_frame && enable);
        wr       = bus.chipselect && bus.write;
        rd       = bus.chipselect && bus.read;
        pos_n    = pos;
        pat_n    = sh_pat;
        fg_n     = sh_fg;
        if (start) begin
            pos_n = '0;
            pat_n = pattern_sel;
            fg_n  = fg_color;
        end else if (xfer) begin
            if (pos.x == XMAX) begin
                pos_n.x    = '0;
                pos_n.y    = pos.y + 10'd1;
                pos_n.bar  = '0;
                pos_n.bcnt = '0;
            end else begin
                pos_n.x = pos.x + 10'd1;
                if (pos.bcnt == BMAX) begin
                    pos_n.bcnt = '0;
                    pos_n.bar  = pos.bar + 3'd1;
                end else begin
                    pos_n.bcnt = pos.bcnt + 7'd1;
                end
            end
        end
        sop_n = (pos_n.x == '0) && (pos_n.y == '0);
        eop_n = (pos_n.x == XMAX) && (pos_n.y == YMAX);
    end

    video_pattern_gen u_gen (
        .x       (pos_n.x),
        .y       (pos_n.y),
        .bar_idx (pos_n.bar),
        .pat     (pat_n),
        .fg      (fg_n),
        .pix     (pix)
    );

    // Frame FSM, counters and registered stream outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= ST_IDLE;
            pos                   <= '0;
            sh_pat                <= '0;
            sh_fg                 <= '0;
            frame_count           <= '0;
            bus.valid_out         <= 1'b0;
            bus.data_out          <= '0;
            bus.startofpacket_out <= 1'b0;
            bus.endofpacket_out   <= 1'b0;
        end else begin
            pos    <= pos_n;
            sh_pat <= pat_n;
            sh_fg  <= fg_n;
            if (eop_xfer)
                frame_count <= frame_count + 16'd1;
            if (start) begin
                state                 <= ST_STREAM;
                bus.valid_out         <= 1'b1;
                bus.data_out          <= pix;
                bus.startofpacket_out <= sop_n;
                bus.endofpacket_out   <= eop_n;
            end else if (eop_xfer) begin
                state                 <= ST_IDLE;
                bus.valid_out         <= 1'b0;
                bus.startofpacket_out <= 1'b0;
                bus.endofpacket_out   <= 1'b0;
            end else if (xfer) begin
                bus.data_out          <= pix;
                bus.startofpacket_out <= sop_n;
                bus.endofpacket_out   <= eop_n;
            end
        end
    end

    // Register file; a software write to reg0 beats the hardware clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            enable       <= 1'b0;
            single_frame <= 1'b0;
            pattern_sel  <= '0;
            fg_color     <= '0;
            bus.readdata <= '0;
        end else begin
            if (wr && bus.address == REG_CTRL) begin
                enable       <= bus.writedata[0];
                single_frame <= bus.writedata[1];
            end else if (eop_xfer && single_frame) begin
                enable <= 1'b0;
            end
            if (wr && bus.address == REG_PAT)
                pattern_sel <= bus.writedata[2:0];
            if (wr && bus.address == REG_FG)
                fg_color <= bus.writedata[15:0];
            if (rd) begin
                unique case (bus.address)
                    REG_CTRL: bus.readdata <= {30'd0, single_frame, enable};
                    REG_PAT:  bus.readdata <= {29'd0, pattern_sel};
                    REG_FG:   bus.readdata <= {16'd0, fg_color};
                    REG_STAT: bus.readdata <= {15'd0, busy, frame_count};
                endcase
            end
        end
    end

endmodule

// File: doc/video_pattern_source.md
Name: video_pattern_source

Overview:
- Avalon-ST video source that generates RGB565 test frames (solid, colour bars, gradient, checkerboard) as packets with startofpacket/endofpacket.
- Drives the camera-side sink of the video effects IP in place of the real camera, so the processing chain can be verified and demoed without a sensor.
- Configured and monitored by the Nios through a small Avalon-MM slave.

Parameters:
- WIDTH, 320, active pixels per line; must be a multiple of 8 and at most 1024.
- HEIGHT, 240, lines per frame; at most 1024.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- chipselect  in  1  Avalon-MM select.
- address  in  2  register index.
- write  in  1  write strobe.
- writedata  in  32  write data.
- read  in  1  read strobe.
- readdata  out  32  read data, registered.
- valid_out  out  1  Avalon-ST valid.
- ready_in  in  1  Avalon-ST ready from the downstream sink.
- data_out  out  16  RGB565 pixel.
- startofpacket_out  out  1  first pixel of frame.
- endofpacket_out  out  1  last pixel of frame.

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: all registers 0, valid_out=0, data_out=0, startofpacket_out=0, endofpacket_out=0, readdata=0, x=y=0, state IDLE.
- Handshake: ready latency 0. A beat transfers when valid_out && ready_in. While valid_out && !ready_in, data_out, startofpacket_out and endofpacket_out are held stable. All ST outputs come from flops.
- Register map, word-addressed:
  - reg0 (RW): bit0 enable, bit1 single_frame.
  - reg1 (RW): bits[2:0] pattern_sel.
  - reg2 (RW): bits[15:0] fg_color.
  - reg3 (RO): bits[15:0] frame_count, bit16 busy. Writes to reg3 are ignored.
  - Unused bits read 0.
  - readdata updates one cycle after chipselect && read. It holds its value otherwise.
- State machine:
  - IDLE -> STREAM when enable=1. On that cycle, pattern_sel and fg_color are latched into shadow registers, x=y=0, and the first beat is presented: valid_out=1, startofpacket_out=1.
  - In STREAM, each transfer advances x. At x=WIDTH-1, x wraps to 0 and y increments. startofpacket_out=1 only for (0,0). endofpacket_out=1 only for (WIDTH-1,HEIGHT-1).
  - On the eop transfer: frame_count += 1 (wraps at 0xFFFF).
    - If single_frame=1, hardware clears enable and the state goes to IDLE.
    - Otherwise, if enable=1, the next frame starts with no gap: the next beat is a sop, and the shadows are reloaded.
    - Otherwise, the state goes to IDLE with valid_out=0.
- busy = (state==STREAM).
- Config changes mid-frame: software writes land in reg0–reg2 immediately but affect only the next frame, through the shadows. Clearing enable mid-frame never truncates a packet; the current frame completes.
- Simultaneous events: if a software write to reg0 coincides with the eop transfer that clears single_frame's enable, the software write wins.
- Patterns, where (x,y) is the current pixel:
  - 0, solid: fg_color.
  - 1, 8 vertical bars, each WIDTH/8 wide, with the bar index kept in a sub-counter (no multiplier). Left to right: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - 2, horizontal grey gradient: {x[7:3], x[7:2], x[7:3]}.
  - 3, checkerboard of 16x16 squares: (x[4]^y[4]) ? ~fg_color : fg_color.
  - 4–7: same as 0.
- Reset mid-frame: outputs drop to their reset values on the next edge. The downstream sink sees a truncated packet; this is accepted and documented for software.

Decomposition:
- Shared package: RGB565 bar-colour constants, pattern_sel encodings, register address constants.
- One natural sub-module, video_pattern_gen: combinational pixel colour from (x, y, bar_idx, shadow pattern, shadow colour). The top level holds the FSM, counters, MM slave and output flops.

Test Plan:
- Reset then enable=1, pattern 0, fg_color=F800, ready_in=1, with WIDTH=16, HEIGHT=4 -> 64 beats of F800; sop on beat 0, eop on beat 63; the next sop follows on the very next cycle; frame_count=1 after the first eop.
- Pattern 1, WIDTH=16 -> each line reads FFFF,FFFF,FFE0,FFE0,…,0000,0000, repeated for all 4 lines.
- ready_in toggled pseudo-randomly, pattern 2 -> data and flags held stable while stalled; the sequence of accepted beats is identical to the ready_in=1 run; no beat is dropped or duplicated.
- enable cleared at beat 20 -> the frame still completes through eop at beat 63; then valid_out=0, busy=0; frame_count increments exactly once.
- single_frame=1, enable=1 -> exactly one frame; reg0 then reads 0x2 (enable cleared by hardware, single_frame still set); reg3 reads 0x00000001.
- reset asserted at beat 30 -> next cycle valid_out=0 and all registers read 0; a re-enable starts at (0,0) with sop.
